// File: rtl/dcache_dataram_skid.sv
// L1 D-cache data storage: 1024x64 byte-writable SRAM with registered read,
// plus an independent 2-entry skid buffer on the coherence request path.
module dcache_dataram_skid #(
    parameter int SKID_W = 76
) (
    input  logic              cpu_clock_i,
    input  logic              cpu_reset_ni,
    input  logic              rd_en_i,
    input  logic [9:0]        rd_addr_i,
    output logic [63:0]       rd_data_o,
    input  logic [7:0]        wr_en_i,
    input  logic [9:0]        wr_addr_i,
    input  logic [63:0]       wr_data_i,
    input  logic              sk_flush_i,
    input  logic              sk_stall_i,
    input  logic [SKID_W-1:0] sk_data_i,
    input  logic              sk_valid_i,
    output logic              sk_busy_o,
    output logic [SKID_W-1:0] sk_data_o,
    output logic              sk_valid_o
);

    logic [63:0] mem [0:1023];

    // Storage array carries no reset so it maps onto an SRAM macro.
    always_ff @(posedge cpu_clock_i) begin
        for (int n = 0; n < 8; n++) begin
            if (wr_en_i[n]) begin
                mem[wr_addr_i][8*n +: 8] <= wr_data_i[8*n +: 8];
            end
        end
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

    logic [SKID_W-1:0] skid_data;
    logic              skid_valid;

    assign sk_busy_o = skid_valid;

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
            sk_valid_o <= 1'b0;
            sk_data_o  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (sk_flush_i) begin
            sk_valid_o <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!sk_stall_i) begin
            if (skid_valid) begin
                sk_data_o  <= skid_data;
                sk_valid_o <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                // Payload only moves with a valid beat so it holds when idle.
                if (sk_valid_i) begin
                    sk_data_o <= sk_data_i;
                end
                sk_valid_o <= sk_valid_i;
            end
        end else if (!sk_valid_o) begin
            if (sk_valid_i) begin
                sk_data_o <= sk_data_i;
            end
            sk_valid_o <= sk_valid_i;
        end else if (sk_valid_i && !skid_valid) begin
            skid_data  <= sk_data_i;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_dataram_skid.sv
// Randomized + directed bench for dcache_dataram_skid against a
// behavioural model (word array for the SRAM, FIFO queue for the skid path).
module tb_dcache_dataram_skid;

    localparam int W = 76;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en = 1'b0;
    logic [9:0]    rd_addr = '0;
    logic [63:0]   rd_data;
    logic [7:0]    wr_en = '0;
    logic [9:0]    wr_addr = '0;
    logic [63:0]   wr_data = '0;
    logic          flush = 1'b0;
    logic          stall = 1'b0;
    logic [W-1:0]  din = '0;
    logic          vin = 1'b0;
    logic          busy;
    logic [W-1:0]  dout;
    logic          vout;

    dcache_dataram_skid #(.SKID_W(W)) dut (
        .cpu_clock_i (clk),
        .cpu_reset_ni(rst_n),
        .rd_en_i     (rd_en),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .sk_flush_i  (flush),
        .sk_stall_i  (stall),
        .sk_data_i   (din),
        .sk_valid_i  (vin),
        .sk_busy_o   (busy),
        .sk_data_o   (dout),
        .sk_valid_o  (vout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [63:0]  mem_m [1024];
    logic [63:0]  rd_exp;
    logic [W-1:0] q [$];
    logic         acc;
    logic         pend;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_payload();
        logic [W-1:0] p;
        p = {$urandom(), $urandom(), $urandom()};
        return p;
    endfunction

    // Advance one clock with the inputs currently driven, updating the
    // model from the rules, then check outputs at the following negedge.
    task automatic step();
        int sz;
        if (rd_en) rd_exp = mem_m[rd_addr];
        for (int b = 0; b < 8; b++)
            if (wr_en[b]) mem_m[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
        sz  = q.size();
        acc = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            acc = vin && (sz < 2);
            if (sz > 0 && !stall) begin
                chk("sk_data", 128'(dout), 128'(q[0]));
                void'(q.pop_front());
            end
            if (acc) q.push_back(din);
        end
        @(negedge clk);
        chk("rd_data", 128'(rd_data), 128'(rd_exp));
        chk("sk_valid", 128'(vout), 128'(q.size() > 0));
        chk("sk_busy", 128'(busy), 128'(q.size() == 2));
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = '0; flush = 1'b0; vin = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_m[i] = '0;
        rd_exp = '0;
        pend = 1'b0;
        #12;
        chk("rst_rd_data", 128'(rd_data), 128'(0));
        chk("rst_sk_valid", 128'(vout), 128'(0));
        chk("rst_sk_busy", 128'(busy), 128'(0));
        chk("rst_sk_data", 128'(dout), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // SRAM full write then read
        wr_en = 8'hFF; wr_addr = 10'h155; wr_data = 64'h0123456789ABCDEF;
        step();
        idle(); rd_en = 1'b1; rd_addr = 10'h155;
        step();
        chk("full_write", 128'(rd_data), 128'h0123456789ABCDEF);

        // Partial write with same-cycle read returning the old word
        wr_en = 8'h0F; wr_addr = 10'h155; wr_data = 64'hFFFFFFFF11223344;
        step();
        chk("rbw_old", 128'(rd_data), 128'h0123456789ABCDEF);
        wr_en = '0;
        step();
        chk("byte_mask", 128'(rd_data), 128'h0123456711223344);
        idle();
        step();
        chk("rd_hold", 128'(rd_data), 128'h0123456711223344);

        // Back-to-back pushes without stall
        stall = 1'b0;
        vin = 1'b1; din = W'('hA); step();
        chk("ns_A", 128'(dout), 128'hA);
        din = W'('hB); step();
        chk("ns_B", 128'(dout), 128'hB);
        din = W'('hC); step();
        chk("ns_C", 128'(dout), 128'hC);
        vin = 1'b0; step();

        // Stalled fill, producer holds C, then release
        stall = 1'b1;
        vin = 1'b1; din = W'('hA1); step();
        din = W'('hB1); step();
        chk("st_busy", 128'(busy), 128'(1));
        din = W'('hC1); step();
        chk("st_held", 128'(dout), 128'hA1);
        stall = 1'b0; step();
        chk("st_rel_B", 128'(dout), 128'hB1);
        step();
        vin = 1'b0; step();
        step();

        // Flush a full buffer; input during flush discarded
        stall = 1'b1;
        vin = 1'b1; din = W'('h11); step();
        din = W'('h22); step();
        flush = 1'b1; din = W'('h33); step();
        chk("fl_valid", 128'(vout), 128'(0));
        chk("fl_busy", 128'(busy), 128'(0));
        chk("fl_data_hold", 128'(dout), 128'h11);
        flush = 1'b0; stall = 1'b0; din = W'('h44); step();
        chk("fl_after", 128'(dout), 128'h44);
        vin = 1'b0; step();

        // Randomized mixed traffic
        for (int c = 0; c < 3000; c++) begin
            rd_en   = $urandom_range(0, 1) == 1;
            rd_addr = 10'($urandom_range(0, 63));
            wr_en   = ($urandom_range(0, 2) == 0) ? 8'($urandom()) : 8'h00;
            wr_addr = 10'($urandom_range(0, 63));
            wr_data = {$urandom(), $urandom()};
            stall   = $urandom_range(0, 1) == 1;
            flush   = $urandom_range(0, 39) == 0;
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                din  = rnd_payload();
            end
            vin = pend;
            step();
            if (acc || flush) pend = 1'b0;
        end
        idle(); stall = 1'b0; pend = 1'b0;
        step(); step(); step();
        chk("drained", 128'(q.size()), 128'(0));

        // Async reset mid-transfer, no clock edge
        rd_en = 1'b1; rd_addr = 10'h155;
        stall = 1'b1; vin = 1'b1; din = W'('h55); step();
        din = W'('h66); step();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rd_data", 128'(rd_data), 128'(0));
        chk("ar_sk_valid", 128'(vout), 128'(0));
        chk("ar_sk_busy", 128'(busy), 128'(0));
        chk("ar_sk_data", 128'(dout), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        q.delete(); rd_exp = '0;
        stall = 1'b0;
        rd_en = 1'b1; rd_addr = 10'h155;
        step();
        chk("retained", 128'(rd_data), 128'h0123456711223344);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
